// File: rtl/fib_bcd_emitter.sv
// Binary-to-BCD emitter for the fibonacci result: double-dabble one bit per clock,
// then streams decimal digits MSD first. Define FIB_BCD_LZ_SUPPRESS_EN to skip leading zeros.
module fib_bcd_emitter #(
  parameter int unsigned WIDTH  = 121,
  parameter int unsigned DIGITS = 37,
  parameter int unsigned CNT_W  = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             busy,
  output logic             digit_valid,
  output logic [3:0]       digit,
  output logic             digit_last,
  input  logic             digit_ready
);

  typedef enum logic [1:0] {StIdle, StShift, StEmit} state_e;

  state_e                  state_q, state_d;
  logic                    in_prev_q;
  logic [WIDTH-1:0]        bin_q, bin_d;
  logic [4*DIGITS-1:0]     bcd_q, bcd_d;
  logic [4*DIGITS-1:0]     bcd_adj;
  logic [4*DIGITS-1:0]     bcd_sel;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        idx_q, idx_d;
  logic                    busy_q, busy_d;
  logic                    start_pulse;
  logic [3:0]              cur_digit;
  logic                    skip;

  assign start_pulse = in_valid & ~in_prev_q;

  // Add-3 correction, confined to each 4-bit digit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign bcd_sel   = bcd_q >> {idx_q, 2'b00};
  assign cur_digit = bcd_sel[3:0];

`ifdef FIB_BCD_LZ_SUPPRESS_EN
  logic seen_q, seen_d;

  assign skip = (state_q == StEmit) && !seen_q && (idx_q != '0) && (cur_digit == 4'd0);
`else
  assign skip = 1'b0;
`endif

  assign digit_valid = (state_q == StEmit) && !skip;
  assign digit       = digit_valid ? cur_digit : 4'd0;
  assign digit_last  = digit_valid && (idx_q == '0);
  assign busy        = busy_q;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
`ifdef FIB_BCD_LZ_SUPPRESS_EN
    seen_d  = seen_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_pulse) begin
          bin_d   = in_data;
          bcd_d   = '0;
          cnt_d   = CNT_W'(WIDTH);
          busy_d  = 1'b1;
          state_d = StShift;
`ifdef FIB_BCD_LZ_SUPPRESS_EN
          seen_d  = 1'b0;
`endif
        end
      end
      StShift: begin
        bcd_d = {bcd_adj[4*DIGITS-2:0], bin_q[WIDTH-1]};
        bin_d = {bin_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = StEmit;
          idx_d   = CNT_W'(DIGITS - 1);
        end
      end
      StEmit: begin
`ifdef FIB_BCD_LZ_SUPPRESS_EN
        if (digit_valid && (cur_digit != 4'd0)) begin
          seen_d = 1'b1;
        end
`endif
        if (skip) begin
          idx_d = idx_q - 1'b1;
        end else if (digit_ready) begin
          if (idx_q == '0) begin
            state_d = StIdle;
            busy_d  = 1'b0;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      in_prev_q <= 1'b0;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
`ifdef FIB_BCD_LZ_SUPPRESS_EN
      seen_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      in_prev_q <= in_valid;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
`ifdef FIB_BCD_LZ_SUPPRESS_EN
      seen_q    <= seen_d;
`endif
    end
  end

endmodule

// File: tb/tb_fib_bcd_emitter.sv
// Self-checking bench for fib_bcd_emitter: decimal-string vectors, random values against an
// arithmetic reference, backpressure, level/edge triggering and asynchronous reset aborts.
module tb_fib_bcd_emitter;

  localparam int WIDTH  = 121;
  localparam int DIGITS = 37;
  localparam int CNT_W  = 7;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             busy;
  logic             digit_valid;
  logic [3:0]       digit;
  logic             digit_last;
  logic             digit_ready;

  int tests = 0;
  int fails = 0;
  int exp_q[$];

  typedef struct {
    logic [WIDTH-1:0] data;
    string            dec;
    int               mode;
  } vec_t;

  vec_t vecs[6];

  fib_bcd_emitter #(.WIDTH(WIDTH), .DIGITS(DIGITS), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .busy       (busy),
    .digit_valid(digit_valid),
    .digit      (digit),
    .digit_last (digit_last),
    .digit_ready(digit_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Expected stream from a decimal string (no leading zeros in the string).
  task automatic from_str(input string s);
    exp_q.delete();
`ifndef FIB_BCD_LZ_SUPPRESS_EN
    repeat (DIGITS - s.len()) exp_q.push_back(0);
`endif
    for (int i = 0; i < s.len(); i++) exp_q.push_back(int'(s[i]) - 48);
  endtask

  // Expected stream from plain decimal arithmetic.
  task automatic model(input logic [WIDTH-1:0] val);
    logic [WIDTH-1:0] v;
    int d[DIGITS];
    bit started;
    v = val;
    for (int i = 0; i < DIGITS; i++) begin
      d[i] = int'(v % 10);
      v    = v / 10;
    end
    exp_q.delete();
    started = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
`ifdef FIB_BCD_LZ_SUPPRESS_EN
      if (d[i] != 0 || i == 0) started = 1'b1;
`else
      started = 1'b1;
`endif
      if (started) exp_q.push_back(d[i]);
    end
  endtask

  task automatic start(input logic [WIDTH-1:0] data);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    in_data  = data;
    in_valid = 1'b1;
  endtask

  // The next rising edge is the capture edge. mode: 0 ready=1, 1 ready 0,0,1 per digit, 2 random.
  task automatic collect(input int mode, input bit keep, input int stop_after, input bit glitch);
    int n, pos, hold, gl, exp_lat;
    bit prev_v, prev_r, r, seen_first, done;
    logic [3:0] prev_d;
    logic prev_l;
    exp_lat = WIDTH + 1;
`ifdef FIB_BCD_LZ_SUPPRESS_EN
    exp_lat += DIGITS - exp_q.size();
`endif
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
    n = 1; pos = 0; hold = 0; gl = 0;
    prev_v = 0; prev_r = 0; prev_d = 0; prev_l = 0; seen_first = 0; done = 0;
    while (!done && n < 4000) begin
      @(negedge clk);
      if (n == 1) check("busy_after_capture", busy, 1);
      if (prev_v && !prev_r) begin
        check("hold_valid", digit_valid, 1);
        check("hold_digit", digit, prev_d);
        check("hold_last", digit_last, prev_l);
      end
      if (digit_valid) begin
        if (!seen_first) check("first_valid_latency", n, exp_lat);
        seen_first = 1;
        if (hold == 0) begin
          check($sformatf("digit[%0d]", pos), digit, exp_q[pos]);
          check($sformatf("last[%0d]", pos), digit_last, pos == exp_q.size() - 1);
        end
        case (mode)
          0:       r = 1'b1;
          1:       r = (hold == 2);
          default: r = 1'($urandom_range(0, 1));
        endcase
        digit_ready = r;
        if (r) begin
          pos++;
          hold = 0;
        end else begin
          hold++;
        end
        prev_v = 1; prev_r = r; prev_d = digit; prev_l = digit_last;
      end else begin
        check("busy_while_working", busy, 1);
        check("valid_gap", {63'd0, seen_first}, 0);
        digit_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        prev_v = 0;
      end
      if (glitch) begin
        if (pos == 2 && gl == 0) begin
          in_valid = 1'b0;
          gl = 1;
        end else if (gl == 1) begin
          in_valid = 1'b1;
          gl = 2;
        end
      end
      if (stop_after > 0 && pos == stop_after) begin
        done = 1;
      end else if (pos == exp_q.size()) begin
        @(negedge clk);
        check("busy_after_last", busy, 0);
        check("valid_after_last", digit_valid, 0);
        done = 1;
      end
      n++;
    end
    if (!done) check("stream_timeout", 1, 0);
  endtask

  task automatic quiet(input string name, input int cycles);
    int bad = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (digit_valid || busy) bad++;
    end
    check(name, bad, 0);
  endtask

  task automatic pulse_reset(input logic lv, input logic [WIDTH-1:0] data);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_async_busy", busy, 0);
    check("rst_async_valid", digit_valid, 0);
    check("rst_async_digit", digit, 0);
    check("rst_async_last", digit_last, 0);
    @(negedge clk);
    in_valid = lv;
    in_data  = data;
    reset    = 1'b1;
  endtask

  initial begin
    logic [127:0] rnd;
    logic [WIDTH-1:0] v;

    vecs[0] = '{121'd8, "8", 0};
    vecs[1] = '{121'd75025, "75025", 0};
    vecs[2] = '{{WIDTH{1'b1}}, "2658455991569831745807614120560689151", 0};
    vecs[3] = '{121'd75025, "75025", 1};
    vecs[4] = '{121'd0, "0", 2};
    vecs[5] = '{121'd1000000000000000000000000000000000000,
                "1000000000000000000000000000000000000", 2};

    reset = 1'b0; in_valid = 1'b0; in_data = '0; digit_ready = 1'b0;
    #12;
    check("reset_busy", busy, 0);
    check("reset_valid", digit_valid, 0);
    check("reset_digit", digit, 0);
    check("reset_last", digit_last, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      from_str(vecs[i].dec);
      start(vecs[i].data);
      collect(vecs[i].mode, 1'b0, 0, 1'b0);
    end

    for (int i = 0; i < 16; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      v   = rnd[WIDTH-1:0] >> $urandom_range(0, WIDTH - 1);
      model(v);
      start(v);
      collect(2, 1'b0, 0, 1'b0);
    end

    // Level held high, with a re-edge during EMIT: exactly one stream.
    model(121'd75025);
    start(121'd75025);
    collect(1, 1'b1, 0, 1'b1);
    quiet("level_hold_no_retrigger", 300);
    model(121'd832040);
    start(121'd832040);
    collect(0, 1'b0, 0, 1'b0);

    // Reset during SHIFT.
    start(121'd987654321);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (59) @(posedge clk);
    pulse_reset(1'b0, '0);
    quiet("no_digits_after_shift_abort", 150);
    model(121'd354224848179261915075);
    start(121'd354224848179261915075);
    collect(0, 1'b0, 0, 1'b0);

    // Reset during EMIT; in_valid high at release counts as a rising edge.
    model({WIDTH{1'b1}});
    start({WIDTH{1'b1}});
    collect(0, 1'b0, 3, 1'b0);
    pulse_reset(1'b1, 121'd12586269025);
    model(121'd12586269025);
    collect(2, 1'b0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fib_bcd_emitter.md
Name: fib_bcd_emitter

Overview:
- Sits directly downstream of the fibonacci stage.
- Captures the wide binary result when the upstream done signal rises.
- Converts the result to packed BCD using an iterative shift-add-3 (double-dabble) datapath, one bit per clock.
- Streams the decimal digits most-significant first over a valid/ready handshake to a display or UART formatter.

Parameters:
- WIDTH, 121: width of the binary input; matches the fibonacci ans port.
- DIGITS, 37: number of BCD digits; must satisfy 10^DIGITS > 2^WIDTH.
- CNT_W, 7: width of the bit counter and the digit index; must hold max(WIDTH, DIGITS).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low; 0 clears all state.
- in_valid  input  1  connected to fibonacci done; a rising edge requests conversion.
- in_data  input  WIDTH  binary value, sampled on the capture edge.
- busy  output  1  high from the capture edge until the last digit is accepted.
- digit_valid  output  1  a digit is presented.
- digit  output  4  BCD digit 0..9.
- digit_last  output  1  qualifies the least-significant digit.
- digit_ready  input  1  consumer accepts the digit when it and digit_valid are both high.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; busy, digit_valid and digit_last are 0; digit=0.
  - Shift register, BCD register, counters and the in_valid edge register are all 0.
  - Reset asserted mid-conversion or mid-emission aborts immediately; no further digits are emitted.
- Edge detect:
  - in_prev registers in_valid every cycle; start_pulse = in_valid & ~in_prev.
  - A level held high (fibonacci done stays high until reset) triggers exactly one conversion.
  - If in_valid is high when reset releases, the first cycle counts as a rising edge.
- IDLE:
  - On start_pulse: bin <= in_data, bcd <= 0, cnt <= WIDTH, busy <= 1, go to SHIFT.
- SHIFT:
  - Each cycle, every 4-bit BCD digit >= 5 gets +3.
  - Then {bcd, bin} shifts left by 1; the bin MSB enters bcd LSB.
  - cnt decrements each cycle; after WIDTH cycles go to EMIT with idx = DIGITS-1.
- EMIT:
  - digit = bcd[idx*4 +: 4]; digit_valid = 1; digit_last = (idx == 0).
  - On handshake: if idx == 0, go to IDLE and busy <= 0 on the same edge; otherwise idx <= idx-1.
  - While digit_valid=1 and digit_ready=0, digit, digit_last and idx hold stable.
  - digit_valid never drops without a handshake except on reset.
- Latency: counting the capture edge as edge 1, digit_valid rises after edge WIDTH+1 (122 with defaults).
- Back-to-back requests:
  - Minimum one IDLE cycle between conversions.
  - A start_pulse while busy=1 is dropped, not queued. This includes the cycle of the final handshake.
- Arithmetic:
  - The add-3 is confined to each 4-bit digit.
  - No overflow is possible given the parameter constraint; all digits stay 0..9.

Optional Feature:
- Macro: FIB_BCD_LZ_SUPPRESS_EN.
- Defined:
  - In EMIT, while no nonzero digit has yet been presented and idx != 0, a zero digit is skipped.
  - A skipped digit costs one cycle with digit_valid=0 and idx decremented; busy stays 1.
  - Digit 0 is always emitted, so the value 0 yields the single digit 0 with digit_last=1.
- Undefined: all DIGITS digits are emitted, including leading zeros.

Test Plan:
- in_data=8, digit_ready=1, macro undefined:
  - 36 digits of 0, then digit 8 with digit_last=1.
  - First digit_valid 122 cycles after the capture edge; busy falls after the 37th handshake.
- in_data=75025, macro defined:
  - Digits 7,5,0,2,5, last flagged on 5; the internal 0 is not suppressed.
  - Exactly 32 skip cycles before the 7.
- in_data=2^121-1:
  - Digits 2658455991569831745807614120560689151 in order.
  - Under the macro: 37 digits, no skips.
- Backpressure, in_data=75025, macro defined:
  - digit_ready toggled 0,0,1 repeatedly -> each digit held stable for 3 cycles; sequence unchanged.
- in_valid held high for 500 cycles after a rising edge -> exactly one digit stream.
  - A second rising edge during EMIT -> ignored.
  - A rising edge after busy falls -> a new conversion.
- reset pulsed low during SHIFT (cycle 60) and again during EMIT (after 3 digits):
  - All outputs are 0 asynchronously, state=IDLE.
  - The next rising edge of in_valid converts the new in_data correctly.
